vga_timing_gen: RTL and testbench

Parameterised VGA raster timing generator. Produces pixel coordinates, sync pulses, blanking, per-line/per-frame strobes and a frame counter for the text/sprite renderers downstream. Also provides copies of sync and display-enable delayed by PIPE_DELAY cycles, so they stay aligned with renderers that register their colour output.

---
 rtl/vga_timing_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: count enable in, raster coordinates/syncs/strobes/pattern out of vga_timing_gen.
interface vga_timing_if;
  logic ena;
  logic [9:0] hpos, vpos;
  logic hsync, vsync, display_on;
  logic line_start, frame_start, vblank_tick;
  logic [7:0] frame_count;
  logic hsync_d, vsync_d, display_on_d;
  logic [5:0] rgb_pat;
  modport master (
    input ena,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, vblank_tick,
    output frame_count, hsync_d, vsync_d, display_on_d, rgb_pat
  );
  modport slave (
    output ena,
    input hpos, vpos, hsync, vsync, display_on, line_start, frame_start, vblank_tick,
    input frame_count, hsync_d, vsync_d, display_on_d, rgb_pat
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing with PIPE_DELAY-aligned sync/enable copies.
// Define VGA_TIMING_PATTERN_EN to add the 8-bar colour test pattern on rgb_pat.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input logic clk,
  input logic rst_n,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP = 10'(V_DISPLAY);
  localparam logic [9:0] HS_ON  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_DISPLAY + V_FRONT + V_SYNC);
`ifdef VGA_TIMING_PATTERN_EN
  localparam int PW = 9;
`else
  localparam int PW = 3;
`endif
  localparam logic [PW-1:0] PIPE_RST = PW'({~SYNC_POL, ~SYNC_POL, 1'b0});
  logic [9:0] hpos, vpos;
  logic [7:0] frame_count;
  logic h_wrap, live, hsync, vsync, display_on, line_start, frame_start, vblank_tick;
  logic [PW-1:0] cur, dly;
  assign h_wrap = hpos >= H_LAST;
  // Out-of-range coordinates collapse to zero on the next enabled clock.
  always_ff @(posedge clk)
    if (!rst_n) begin
      hpos        <= 10'd0;
      vpos        <= 10'd0;
      frame_count <= 8'd0;
    end else if (bus.ena) begin
      hpos <= h_wrap ? 10'd0 : hpos + 10'd1;
      vpos <= (vpos > V_LAST || (h_wrap && vpos == V_LAST)) ? 10'd0 : vpos + 10'(h_wrap);
      if (vblank_tick) frame_count <= frame_count + 8'd1;
    end
  always_comb begin
    live        = bus.ena & rst_n;
    hsync       = (hpos >= HS_ON && hpos < HS_OFF) ? SYNC_POL : ~SYNC_POL;
    vsync       = (vpos >= VS_ON && vpos < VS_OFF) ? SYNC_POL : ~SYNC_POL;
    display_on  = hpos < H_DISP && vpos < V_DISP;
    line_start  = live && hpos == 10'd0;
    frame_start = line_start && vpos == 10'd0;
    vblank_tick = line_start && vpos == V_DISP;
  end
`ifdef VGA_TIMING_PATTERN_EN
  assign cur = {{2{hpos[9]}}, {2{hpos[8]}}, {2{hpos[7]}}, hsync, vsync, display_on};
  assign bus.rgb_pat = dly[0] ? dly[8:3] : 6'b0;
`else
  assign cur = {hsync, vsync, display_on};
  assign bus.rgb_pat = 6'b0;
`endif
  generate
    if (PIPE_DELAY == 0) begin : g_nopipe
      assign dly = cur;
    end else begin : g_pipe
      logic [PW-1:0] sr [PIPE_DELAY];
      always_ff @(posedge clk)
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) sr[i] <= PIPE_RST;
        end else if (bus.ena) begin
          sr[0] <= cur;
          for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= sr[i-1];
        end
      assign dly = sr[PIPE_DELAY-1];
    end
  endgenerate
  assign bus.hpos         = hpos;
  assign bus.vpos         = vpos;
  assign bus.hsync        = hsync;
  assign bus.vsync        = vsync;
  assign bus.display_on   = display_on;
  assign bus.line_start   = line_start;
  assign bus.frame_start  = frame_start;
  assign bus.vblank_tick  = vblank_tick;
  assign bus.frame_count  = frame_count;
  assign bus.hsync_d      = dly[2];
  assign bus.vsync_d      = dly[1];
  assign bus.display_on_d = dly[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors, corner sequences and a raster-count reference model over three configurations.
`define PACK(x) {x.hpos, x.vpos, x.hsync, x.vsync, x.display_on, x.line_start, x.frame_start, x.vblank_tick, x.frame_count, x.hsync_d, x.vsync_d, x.display_on_d, x.rgb_pat}
module tb_vga_timing_gen;
  localparam int S_HD = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VD = 12, S_VF = 2, S_VS = 2, S_VB = 3;
  typedef struct {int hd, hf, hs, hb, vd, vf, vs, vb, pd; bit pol;} cfg_t;
  typedef struct {int t, h, v, hs, de, ls, fs, hsd;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  int total = 0, bad = 0, cnt = 0, rc = 0;
  longint t = 0;
  bit valid = 1'b0;
  cfg_t cfg [3];
  vec_t tbl [11];
  logic [42:0] o [3];
  always #5 clk = ~clk;
  vga_timing_if v0 (), v1 (), v2 ();
  assign v0.ena = ena;
  assign v1.ena = ena;
  assign v2.ena = ena;
  vga_timing_gen u0 (.clk(clk), .rst_n(rst_n), .bus(v0));
  vga_timing_gen #(.H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_POL(1'b1), .PIPE_DELAY(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(v1));
  vga_timing_gen #(.H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_POL(1'b0), .PIPE_DELAY(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(v2));
  assign o[0] = `PACK(v0);
  assign o[1] = `PACK(v1);
  assign o[2] = `PACK(v2);

  // Position after t enabled clocks since reset: {hsync, vsync, display_on, gated bar colour}.
  function automatic logic [8:0] dec(cfg_t c, longint t);
    longint ht = c.hd + c.hf + c.hs + c.hb;
    longint vt = c.vd + c.vf + c.vs + c.vb;
    longint h = t % ht;
    longint v = (t / ht) % vt;
    logic hsy = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.pol : ~c.pol;
    logic vsy = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.pol : ~c.pol;
    logic de = h < c.hd && v < c.vd;
    logic [2:0] n = 3'(h / 128);
    return {hsy, vsy, de, de ? {n[2], n[2], n[1], n[1], n[0], n[0]} : 6'b0};
  endfunction

  function automatic logic [42:0] expw(cfg_t c, longint t, bit en, bit rn);
    longint ht = c.hd + c.hf + c.hs + c.hb;
    longint vt = c.vd + c.vf + c.vs + c.vb;
    longint f = ht * vt;
    longint h = t % ht;
    longint v = (t / ht) % vt;
    longint off = c.vd * ht;
    logic [8:0] d = dec(c, t);
    logic [8:0] dd = (t >= c.pd) ? dec(c, t - c.pd) : {~c.pol, ~c.pol, 7'b0};
    logic ls = en && rn && h == 0;
    logic [7:0] fc = (t > off) ? 8'((t - 1 - off) / f + 1) : 8'd0;
    logic [5:0] rgb = 6'b0;
`ifdef VGA_TIMING_PATTERN_EN
    rgb = dd[5:0];
`endif
    return {10'(h), 10'(v), d[8:6], ls, ls && v == 0, ls && v == c.vd, fc, dd[8:6], rgb};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit en, input bit rn);
    @(negedge clk);
    ena = en;
    rst_n = rn;
    #1;
    if (valid)
      for (int k = 0; k < 3; k++) chk($sformatf("model_dut%0d_t%0d", k, t), 64'(o[k]), 64'(expw(cfg[k], t, en, rn)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      t = 0;
      valid = 1'b1;
    end else if (ena) t++;
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0};
    cfg[1] = '{S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 2, 1'b1};
    cfg[2] = '{S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 0, 1'b0};
    tbl = '{'{0, 0, 0, 1, 1, 1, 1, 1}, '{1, 1, 0, 1, 1, 0, 0, 1}, '{639, 639, 0, 1, 1, 0, 0, 1},
            '{640, 640, 0, 1, 0, 0, 0, 1}, '{656, 656, 0, 0, 0, 0, 0, 1}, '{657, 657, 0, 0, 0, 0, 0, 0},
            '{751, 751, 0, 0, 0, 0, 0, 0}, '{752, 752, 0, 1, 0, 0, 0, 0}, '{753, 753, 0, 1, 0, 0, 0, 1},
            '{799, 799, 0, 1, 0, 0, 0, 1}, '{800, 0, 1, 1, 1, 1, 0, 1}};
    drive(1, 0); tick();
    drive(1, 0); tick();
    for (int i = 0; i < 11;) begin
      drive(1, 1);
      if (t == tbl[i].t) begin
        chk($sformatf("tbl%0d_hpos", i), 64'(v0.hpos), 64'(tbl[i].h));
        chk($sformatf("tbl%0d_vpos", i), 64'(v0.vpos), 64'(tbl[i].v));
        chk($sformatf("tbl%0d_hsync", i), 64'(v0.hsync), 64'(tbl[i].hs));
        chk($sformatf("tbl%0d_de", i), 64'(v0.display_on), 64'(tbl[i].de));
        chk($sformatf("tbl%0d_ls", i), 64'(v0.line_start), 64'(tbl[i].ls));
        chk($sformatf("tbl%0d_fs", i), 64'(v0.frame_start), 64'(tbl[i].fs));
        chk($sformatf("tbl%0d_hsd", i), 64'(v0.hsync_d), 64'(tbl[i].hsd));
        i++;
      end
      tick();
    end
    while (t < 900) begin drive(1, 1); tick(); end
    repeat (10) begin
      drive(0, 1);
      chk("hold_hpos", 64'(v0.hpos), 64'd100);
      chk("hold_ls", 64'(v0.line_start), 64'd0);
      chk("hold_fc", 64'(v0.frame_count), 64'd0);
      tick();
    end
    drive(1, 1); chk("resume_hpos0", 64'(v0.hpos), 64'd100); tick();
    drive(1, 1); chk("resume_hpos1", 64'(v0.hpos), 64'd101); tick();
    while (t < 1600) begin drive(1, 1); tick(); end
    drive(0, 1);
    chk("gate_hpos", 64'(v0.hpos), 64'd0);
    chk("gate_ls", 64'(v0.line_start), 64'd0);
    tick();
    drive(1, 1); chk("ungate_ls", 64'(v0.line_start), 64'd1); tick();
    while (t < 1700) begin drive(1, 1); tick(); end
    drive(1, 0); chk("rst_fs_pre", 64'(v0.frame_start), 64'd0); tick();
    drive(1, 0);
    chk("rst_hpos", 64'(v0.hpos), 64'd0);
    chk("rst_vpos", 64'(v0.vpos), 64'd0);
    chk("rst_fc", 64'(v0.frame_count), 64'd0);
    chk("rst_hsd", 64'(v0.hsync_d), 64'd1);
    chk("rst_ded", 64'(v0.display_on_d), 64'd0);
    chk("rst_fs", 64'(v0.frame_start), 64'd0);
    chk("rst_hsd_pol1", 64'(v1.hsync_d), 64'd0);
    tick();
    drive(1, 1); chk("rel_fs", 64'(v0.frame_start), 64'd1); tick();
    while (t < 608) begin
      drive(1, 1);
      cnt += int'(v1.vblank_tick);
      chk("pd0_hsd", 64'(v2.hsync_d), 64'(v2.hsync));
      if (t == 23) chk("pd2_hs_on", 64'(v1.hsync), 64'd1);
      if (t == 24) chk("pd2_hsd_pre", 64'(v1.hsync_d), 64'd0);
      if (t == 25) chk("pd2_hsd_on", 64'(v1.hsync_d), 64'd1);
      tick();
    end
    drive(1, 1);
    chk("frame_vt_count", 64'(cnt), 64'd1);
    chk("frame_fc", 64'(v1.frame_count), 64'd1);
    chk("frame_fs", 64'(v1.frame_start), 64'd1);
    chk("frame_pos", 64'({v1.hpos, v1.vpos}), 64'd0);
    tick();
    repeat (15000) begin
      if (rc > 0) rc--;
      else if ($urandom_range(0, 1999) == 0) rc = $urandom_range(1, 3);
      drive($urandom_range(0, 7) != 0, rc == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
